jbitser: RTL and testbench
==========================

JBITSER -- requirements
Module: jbitser

Interface
REQ-001 Parameter: N, 8, operand width in bits (legal 2..32).
REQ-002 wclk  input  1  single clock; all state updates on rising edge.
REQ-003 wrst_n  input  1  reset; asynchronous, active-low.
REQ-004 wstart  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-005 wop  input  1  operation select: 0 = add, 1 = compare.
REQ-006 wa  input  N  operand A, captured on accepted start.
REQ-007 wb  input  N  operand B, captured on accepted start.
REQ-008 wci  input  1  add carry-in, captured on accepted start; ignored for compare.
REQ-009 wbusy  output  1  high while in RUN.
REQ-010 wdone  output  1  one-cycle pulse in DONE.
REQ-011 wc  output  N  add: sum; compare: bitwise A xor B.
REQ-012 wco  output  1  add carry-out; 0 after compare.
REQ-013 weqo  output  1  compare: A == B; 0 after add.
REQ-014 walo  output  1  compare: A > B unsigned; 0 after add.

Function
REQ-015 A single jadd cell (add) or a single jcmp cell (compare) is time-shared across the N bit positions; no N-wide adder or comparator exists.
REQ-016 States: IDLE, RUN, DONE; IDLE->RUN on wstart; RUN->DONE after exactly N bit-cycles; DONE->RUN if wstart, else DONE->IDLE.
REQ-017 Start accepted at edge t; bit-cycles occupy edges t+1..t+N; wdone high during the cycle after edge t+N; latency start-to-wdone = N+1 cycles.
REQ-018 Add: bits processed LSB first; carry register initialised from wci, updated with jadd carry-out each bit-cycle; wco = final carry.
REQ-019 Compare: bits processed MSB first; eq register initialised 1, alarger register initialised 0, chained through jcmp each bit-cycle.
REQ-020 wstart while in RUN is ignored; captured operands and op are not disturbed.
REQ-021 Changes on wa/wb/wop/wci after acceptance have no effect on the running operation.
REQ-022 wc/wco/weqo/walo hold the last completed result from DONE until the next accepted start; their values during RUN are don't-care except that they are not X.
REQ-023 N-bit bit index wraps to 0 on entering RUN; no carry or index overflow beyond N bit-cycles.

Reset
REQ-024 wrst_n low forces IDLE immediately, independent of wclk, including mid-RUN; the aborted operation produces no wdone.
REQ-025 Reset values: wbusy=0, wdone=0, wc=0, wco=0, weqo=0, walo=0, bit counter=0.
REQ-026 First start is accepted on the first rising edge after wrst_n deasserts.

Configuration
REQ-027 Macro JBITSER_ZERO_EN: when defined, output wzero (1 bit) is present and equals 1 when wc is all zeros, valid from DONE until next start, reset 0; when undefined, port and logic are absent and all other behaviour is identical.

Structure
REQ-028 Package jbitser_pkg holds the state encoding (IDLE, RUN, DONE) and op codes (OP_ADD=0, OP_CMP=1).
REQ-029 One sub-module jbitctr: loadable down-counter, width clog2(N)+1, with terminal-count flag driving RUN->DONE.
REQ-030 jadd, jcmp, jand, jor, jnot from the gate library are instantiated for the bit cell; no behavioural + or < operators.

Verification
REQ-031 N=8, add 0x0F+0x01 wci=0 -> wc=0x10, wco=0, wdone exactly 9 cycles after start edge.
REQ-032 Add 0xFF+0x00 wci=1 -> wc=0x00, wco=1, weqo=0, walo=0.
REQ-033 Compare 0x80 vs 0x7F -> walo=1, weqo=0, wc=0xFF, wco=0; compare 0x55 vs 0x55 -> weqo=1, walo=0, wc=0x00.
REQ-034 Start add 0x01+0x01, pulse wstart with new operands at cycle 3 -> result 0x02, single wdone; back-to-back start in DONE -> second wdone N+1 cycles later.
REQ-035 Assert wrst_n low at cycle 4 of RUN -> all outputs 0 asynchronously, no wdone, next start completes normally.
REQ-036 With JBITSER_ZERO_EN: add 0x80+0x80 -> wc=0x00, wco=1, wzero=1; without it the bench compiles without wzero.

Source files
------------

// File: rtl/jbitser_pkg.sv
// Shared types for the bit-serial add/compare unit: FSM encoding and op codes.
package jbitser_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_CMP = 1'b1;
endpackage

// File: rtl/jbitser_if.sv
// Request/result bundle for jbitser; wzero exists only when JBITSER_ZERO_EN is defined.
interface jbitser_if #(parameter int N = 8);
  logic         wstart;
  logic         wop;
  logic [N-1:0] wa;
  logic [N-1:0] wb;
  logic         wci;
  logic         wbusy;
  logic         wdone;
  logic [N-1:0] wc;
  logic         wco;
  logic         weqo;
  logic         walo;
`ifdef JBITSER_ZERO_EN
  logic         wzero;
  modport master (output wstart, wop, wa, wb, wci,
                  input  wbusy, wdone, wc, wco, weqo, walo, wzero);
  modport slave  (input  wstart, wop, wa, wb, wci,
                  output wbusy, wdone, wc, wco, weqo, walo, wzero);
`else
  modport master (output wstart, wop, wa, wb, wci,
                  input  wbusy, wdone, wc, wco, weqo, walo);
  modport slave  (input  wstart, wop, wa, wb, wci,
                  output wbusy, wdone, wc, wco, weqo, walo);
`endif
endinterface

// File: rtl/jbitctr.sv
// Loadable bit-cycle down-counter; tc marks the last bit-cycle of a run.
module jbitctr #(parameter int W = 4) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic         ld,
  input  logic         en,
  input  logic [W-1:0] ldv,
  output logic         tc
);
  logic [W-1:0] cnt;

  // Saturates at zero so an idle enable can never wrap the count.
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n)                cnt <= '0;
    else if (ld)                cnt <= ldv;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);

  assign tc = (cnt == '0);
endmodule

// File: rtl/jgates.sv
// Gate library leaf cells used to build the time-shared bit cell.
module jadd (input logic a, input logic b, input logic ci, output logic s, output logic co);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// One MSB-first step of an unsigned magnitude compare.
module jcmp (input logic a, input logic b, input logic eqi, input logic gti,
             output logic eqo, output logic gto);
  assign eqo = eqi & ~(a ^ b);
  assign gto = gti | (eqi & a & ~b);
endmodule

module jand (input logic a, input logic b, output logic y);
  assign y = a & b;
endmodule

module jor (input logic a, input logic b, output logic y);
  assign y = a | b;
endmodule

module jnot (input logic a, output logic y);
  assign y = ~a;
endmodule

// File: rtl/jbitser.sv
// Bit-serial N-bit add (LSB first) / unsigned compare (MSB first) on one shared bit cell.
// Optional zero-result flag under JBITSER_ZERO_EN.
module jbitser
  import jbitser_pkg::*;
#(
  parameter int N = 8
) (
  input logic     wclk,
  input logic     wrst_n,
  jbitser_if.slave bus
);
  localparam int W = $clog2(N) + 1;

  state_t       st;
  logic [N-1:0] a_r, b_r, c_r, c_nxt;
  logic         op_r, carry, eq, alg;
  logic         busy, done, co_r, eqo_r, alo_r;
  logic         cmp, abit, bbit, sum, cout, ceq, cgt;
  logic         x_or, x_and, x_nand, x_bit, rbit, tc, ld;
`ifdef JBITSER_ZERO_EN
  logic         zero_r;
`endif

  assign cmp  = (op_r == OP_CMP);
  assign abit = cmp ? a_r[N-1] : a_r[0];
  assign bbit = cmp ? b_r[N-1] : b_r[0];

  jadd u_add (.a(abit), .b(bbit), .ci(carry), .s(sum), .co(cout));
  jcmp u_cmp (.a(abit), .b(bbit), .eqi(eq), .gti(alg), .eqo(ceq), .gto(cgt));

  // Compare result bit is a^b, built from the library cells.
  jor  u_or   (.a(abit),  .b(bbit),   .y(x_or));
  jand u_and  (.a(abit),  .b(bbit),   .y(x_and));
  jnot u_not  (.a(x_and), .y(x_nand));
  jand u_xand (.a(x_or),  .b(x_nand), .y(x_bit));

  assign rbit  = cmp ? x_bit : sum;
  // Result shifts toward the end it started from so the last bit lands in place.
  assign c_nxt = cmp ? {c_r[N-2:0], rbit} : {rbit, c_r[N-1:1]};
  assign ld    = bus.wstart && (st != RUN);

  jbitctr #(.W(W)) u_ctr (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .ld    (ld),
    .en    (st == RUN),
    .ldv   (W'(N - 1)),
    .tc    (tc)
  );

  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      st    <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      c_r   <= '0;
      op_r  <= OP_ADD;
      carry <= 1'b0;
      eq    <= 1'b0;
      alg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      co_r  <= 1'b0;
      eqo_r <= 1'b0;
      alo_r <= 1'b0;
`ifdef JBITSER_ZERO_EN
      zero_r <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (st)
        RUN: begin
          a_r   <= cmp ? {a_r[N-2:0], 1'b0} : {1'b0, a_r[N-1:1]};
          b_r   <= cmp ? {b_r[N-2:0], 1'b0} : {1'b0, b_r[N-1:1]};
          c_r   <= c_nxt;
          carry <= cout;
          eq    <= ceq;
          alg   <= cgt;
          if (tc) begin
            st    <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            co_r  <= ~cmp & cout;
            eqo_r <= cmp & ceq;
            alo_r <= cmp & cgt;
`ifdef JBITSER_ZERO_EN
            zero_r <= (c_nxt == '0);
`endif
          end
        end
        default: begin
          if (bus.wstart) begin
            st    <= RUN;
            busy  <= 1'b1;
            a_r   <= bus.wa;
            b_r   <= bus.wb;
            op_r  <= bus.wop;
            carry <= bus.wci;
            eq    <= 1'b1;
            alg   <= 1'b0;
          end else begin
            st <= IDLE;
          end
        end
      endcase
    end

  assign bus.wbusy = busy;
  assign bus.wdone = done;
  assign bus.wc    = c_r;
  assign bus.wco   = co_r;
  assign bus.weqo  = eqo_r;
  assign bus.walo  = alo_r;
`ifdef JBITSER_ZERO_EN
  assign bus.wzero = zero_r;
`endif
endmodule

// File: tb/tb_jbitser.sv
// Directed bench for jbitser (N=8): add/compare vectors, start-in-RUN, back-to-back, async reset.
module tb_jbitser;
  logic wclk;
  logic wrst_n;
  int   pass  = 0;
  int   fail  = 0;
  int   total = 0;
  int   lat;
  int   ndone;

  jbitser_if #(.N(8)) bus ();
  jbitser #(.N(8)) dut (.wclk(wclk), .wrst_n(wrst_n), .bus(bus));

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else begin
      fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic op, input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge wclk);
    bus.wop = op; bus.wa = a; bus.wb = b; bus.wci = ci; bus.wstart = 1'b1;
    @(posedge wclk);
    #1 bus.wstart = 1'b0;
  endtask

  // Called #1 after an edge; cycle 1 is the cycle right after the accepting edge.
  task automatic wait_done(input int start_cyc, output int l);
    l = start_cyc;
    while (bus.wdone !== 1'b1 && l < 40) begin
      @(posedge wclk); #1;
      l++;
    end
  endtask

  initial begin
    bus.wstart = 1'b0; bus.wop = 1'b0; bus.wa = '0; bus.wb = '0; bus.wci = 1'b0;
    wrst_n = 1'b1;
    #1 wrst_n = 1'b0;
    #1;
    chk("rst_busy", bus.wbusy, 0);
    chk("rst_done", bus.wdone, 0);
    chk("rst_wc",   bus.wc,    0);
    chk("rst_wco",  bus.wco,   0);
    chk("rst_weqo", bus.weqo,  0);
    chk("rst_walo", bus.walo,  0);
`ifdef JBITSER_ZERO_EN
    chk("rst_wzero", bus.wzero, 0);
`endif
    @(negedge wclk) wrst_n = 1'b1;

    // 0x0F + 0x01
    go(1'b0, 8'h0F, 8'h01, 1'b0);
    chk("add1_busy_run", bus.wbusy, 1);
    wait_done(1, lat);
    chk("add1_latency", 32'(lat), 9);
    chk("add1_wc",   bus.wc,   8'h10);
    chk("add1_wco",  bus.wco,  0);
    chk("add1_busy_done", bus.wbusy, 0);
`ifdef JBITSER_ZERO_EN
    chk("add1_wzero", bus.wzero, 0);
`endif
    @(posedge wclk); #1;
    chk("add1_done_pulse", bus.wdone, 0);
    chk("add1_wc_hold", bus.wc, 8'h10);

    // 0xFF + 0x00 + 1
    go(1'b0, 8'hFF, 8'h00, 1'b1);
    wait_done(1, lat);
    chk("add2_wc",   bus.wc,   8'h00);
    chk("add2_wco",  bus.wco,  1);
    chk("add2_weqo", bus.weqo, 0);
    chk("add2_walo", bus.walo, 0);

    // compare 0x80 vs 0x7F
    go(1'b1, 8'h80, 8'h7F, 1'b1);
    wait_done(1, lat);
    chk("cmp1_walo", bus.walo, 1);
    chk("cmp1_weqo", bus.weqo, 0);
    chk("cmp1_wc",   bus.wc,   8'hFF);
    chk("cmp1_wco",  bus.wco,  0);

    // compare 0x55 vs 0x55
    go(1'b1, 8'h55, 8'h55, 1'b0);
    wait_done(1, lat);
    chk("cmp2_weqo", bus.weqo, 1);
    chk("cmp2_walo", bus.walo, 0);
    chk("cmp2_wc",   bus.wc,   8'h00);

    // compare 0x3C vs 0x5A (A < B)
    go(1'b1, 8'h3C, 8'h5A, 1'b0);
    wait_done(1, lat);
    chk("cmp3_weqo", bus.weqo, 0);
    chk("cmp3_walo", bus.walo, 0);
    chk("cmp3_wc",   bus.wc,   8'h66);

    // start pulse with new operands during RUN must be ignored
    go(1'b0, 8'h01, 8'h01, 1'b0);
    repeat (2) @(posedge wclk);
    #1;
    bus.wop = 1'b1; bus.wa = 8'hFF; bus.wb = 8'hFF; bus.wci = 1'b1; bus.wstart = 1'b1;
    @(posedge wclk);
    #1 bus.wstart = 1'b0;
    wait_done(4, lat);
    chk("ign_latency", 32'(lat), 9);
    chk("ign_wc",  bus.wc,  8'h02);
    chk("ign_wco", bus.wco, 0);
    ndone = 0;
    repeat (12) begin
      @(posedge wclk); #1;
      if (bus.wdone === 1'b1) ndone++;
    end
    chk("ign_extra_done", 32'(ndone), 0);

    // back-to-back: restart while in DONE
    go(1'b0, 8'h33, 8'h44, 1'b1);
    wait_done(1, lat);
    chk("b2b1_wc", bus.wc, 8'h78);
    bus.wop = 1'b1; bus.wa = 8'h12; bus.wb = 8'h13; bus.wci = 1'b0; bus.wstart = 1'b1;
    @(posedge wclk);
    #1 bus.wstart = 1'b0;
    wait_done(1, lat);
    chk("b2b2_latency", 32'(lat), 9);
    chk("b2b2_wc",   bus.wc,   8'h01);
    chk("b2b2_walo", bus.walo, 0);
    chk("b2b2_weqo", bus.weqo, 0);

    // asynchronous reset at cycle 4 of RUN
    go(1'b0, 8'h0F, 8'h0F, 1'b0);
    repeat (3) @(posedge wclk);
    #2;
    chk("ar_busy_before", bus.wbusy, 1);
    wrst_n = 1'b0;
    #1;
    chk("ar_busy", bus.wbusy, 0);
    chk("ar_done", bus.wdone, 0);
    chk("ar_wc",   bus.wc,    0);
    chk("ar_wco",  bus.wco,   0);
    chk("ar_weqo", bus.weqo,  0);
    chk("ar_walo", bus.walo,  0);
    ndone = 0;
    repeat (10) begin
      @(posedge wclk); #1;
      if (bus.wdone === 1'b1) ndone++;
    end
    chk("ar_no_done", 32'(ndone), 0);
    @(negedge wclk);
    wrst_n = 1'b1;
    bus.wop = 1'b0; bus.wa = 8'h21; bus.wb = 8'h10; bus.wci = 1'b1; bus.wstart = 1'b1;
    @(posedge wclk);
    #1 bus.wstart = 1'b0;
    wait_done(1, lat);
    chk("ar_next_latency", 32'(lat), 9);
    chk("ar_next_wc",  bus.wc,  8'h32);
    chk("ar_next_wco", bus.wco, 0);

    // 0x80 + 0x80: zero result with carry-out
    go(1'b0, 8'h80, 8'h80, 1'b0);
    wait_done(1, lat);
    chk("z_wc",  bus.wc,  8'h00);
    chk("z_wco", bus.wco, 1);
`ifdef JBITSER_ZERO_EN
    chk("z_wzero", bus.wzero, 1);
`endif

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
